// File: rtl/pwm_bank.sv
// Multi-channel PWM generator: one shared period counter, per-channel duty/polarity, double-buffered settings, burst mode.
// Latency: pwm_out is registered and lines up with the cycle's counter value; period_end/busy/burst_done decode registered state.
// No backpressure: load and burst_start are single-cycle strobes that are always accepted (burst_start outside IDLE is dropped).
module pwm_bank #(
    parameter int NUM_CH   = 4,
    parameter int PERIOD_W = 16,
    parameter int BURST_W  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [PERIOD_W-1:0]          period,
    input  logic [NUM_CH*PERIOD_W-1:0]   duty,
    input  logic [NUM_CH-1:0]            polarity,
    input  logic                         load,
    input  logic                         burst_mode,
    input  logic [BURST_W-1:0]           burst_len,
    input  logic                         burst_start,
    output logic [NUM_CH-1:0]            pwm_out,
    output logic                         period_end,
    output logic                         busy,
    output logic                         load_pending,
    output logic                         burst_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        BURST = 2'd2
    } state_t;

    localparam logic [PERIOD_W-1:0] P_ONE = PERIOD_W'(1);
    localparam logic [BURST_W-1:0]  B_ONE = BURST_W'(1);

    state_t                       state, state_nxt;
    logic [PERIOD_W-1:0]          cnt, cnt_nxt;
    logic [BURST_W-1:0]           bcnt, bcnt_nxt;
    logic                         zero_done, zero_done_nxt;

    // Shadow copies written by load, and the copies that actually drive the compare.
    logic [PERIOD_W-1:0]          sh_period;
    logic [NUM_CH*PERIOD_W-1:0]   sh_duty;
    logic [NUM_CH-1:0]            sh_pol;
    logic [PERIOD_W-1:0]          act_period, act_period_nxt;
    logic [NUM_CH*PERIOD_W-1:0]   act_duty, act_duty_nxt;
    logic [NUM_CH-1:0]            act_pol, act_pol_nxt;
    logic                         pend_nxt;

    logic [PERIOD_W-1:0]          last_cnt;
    logic                         in_idle;
    logic                         at_end;
    logic                         xfer_ok;
    logic [NUM_CH-1:0]            pwm_nxt;

    // Period values 0 and 1 both collapse to a single-cycle period.
    assign last_cnt = (act_period <= P_ONE) ? '0 : (act_period - P_ONE);
    assign in_idle  = (state == IDLE);
    assign at_end   = !in_idle && (cnt == last_cnt);
    assign xfer_ok  = in_idle || at_end;

    assign period_end = at_end;
    assign busy       = !in_idle;
    // Final period of a burst, or the deferred pulse for a zero-length burst request.
    assign burst_done = ((state == BURST) && at_end && (bcnt == B_ONE)) || zero_done;

    // Pick the settings that govern the next cycle: a load at a boundary goes straight
    // to active, otherwise pending shadow contents move over at the boundary.
    always_comb begin
        act_period_nxt = act_period;
        act_duty_nxt   = act_duty;
        act_pol_nxt    = act_pol;
        pend_nxt       = load_pending;
        if (load && xfer_ok) begin
            act_period_nxt = period;
            act_duty_nxt   = duty;
            act_pol_nxt    = polarity;
            pend_nxt       = 1'b0;
        end else if (load) begin
            pend_nxt       = 1'b1;
        end else if (load_pending && xfer_ok) begin
            act_period_nxt = sh_period;
            act_duty_nxt   = sh_duty;
            act_pol_nxt    = sh_pol;
            pend_nxt       = 1'b0;
        end
    end

    // Next-state, counter and burst-count decode.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        bcnt_nxt      = bcnt;
        zero_done_nxt = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (en) begin
                    if (!burst_mode) begin
                        state_nxt = RUN;
                    end else if (burst_start) begin
                        if (burst_len != '0) begin
                            state_nxt = BURST;
                            bcnt_nxt  = burst_len;
                        end else begin
                            zero_done_nxt = 1'b1;
                        end
                    end
                end
            end
            RUN: begin
                if (!en) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = at_end ? '0 : (cnt + P_ONE);
                end
            end
            BURST: begin
                if (!en) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    bcnt_nxt  = '0;
                end else if (at_end) begin
                    cnt_nxt = '0;
                    if (bcnt == B_ONE) begin
                        state_nxt = IDLE;
                        bcnt_nxt  = '0;
                    end else begin
                        bcnt_nxt = bcnt - B_ONE;
                    end
                end else begin
                    cnt_nxt = cnt + P_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                bcnt_nxt  = '0;
            end
        endcase
    end

    // Per-channel compare against the counter value the next cycle will show.
    always_comb begin
        pwm_nxt = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (state_nxt == IDLE) begin
                pwm_nxt[k] = act_pol_nxt[k];
            end else begin
                pwm_nxt[k] = (cnt_nxt < act_duty_nxt[k*PERIOD_W +: PERIOD_W]) ^ act_pol_nxt[k];
            end
        end
    end

    // State, counters and the deferred zero-length done flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bcnt      <= '0;
            zero_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bcnt      <= bcnt_nxt;
            zero_done <= zero_done_nxt;
        end
    end

    // Shadow capture on every load strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_period <= '0;
            sh_duty   <= '0;
            sh_pol    <= '0;
        end else if (load) begin
            sh_period <= period;
            sh_duty   <= duty;
            sh_pol    <= polarity;
        end
    end

    // Active settings, pending flag and the registered PWM outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_period   <= '0;
            act_duty     <= '0;
            act_pol      <= '0;
            load_pending <= 1'b0;
            pwm_out      <= '0;
        end else begin
            act_period   <= act_period_nxt;
            act_duty     <= act_duty_nxt;
            act_pol      <= act_pol_nxt;
            load_pending <= pend_nxt;
            pwm_out      <= pwm_nxt;
        end
    end

endmodule

// File: doc/pwm_bank.md
PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 Parameter NUM_CH, default 4: number of PWM channels sharing one period counter.
REQ-002 Parameter PERIOD_W, default 16: width of period, duty and counter.
REQ-003 Parameter BURST_W, default 8: width of burst_len and burst counter.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 en  in  1  global enable; 0 forces IDLE.
REQ-007 period  in  PERIOD_W  period length in clk cycles.
REQ-008 duty  in  NUM_CH*PERIOD_W  per-channel active-cycle count; channel k at bits [k*PERIOD_W +: PERIOD_W].
REQ-009 polarity  in  NUM_CH  per-channel inversion; 1 = active-low output.
REQ-010 load  in  1  one-cycle strobe capturing period/duty/polarity into shadow registers.
REQ-011 burst_mode  in  1  0 = continuous, 1 = burst.
REQ-012 burst_len  in  BURST_W  periods per burst, sampled on burst_start.
REQ-013 burst_start  in  1  one-cycle strobe starting a burst.
REQ-014 pwm_out  out  NUM_CH  PWM outputs, registered.
REQ-015 period_end  out  1  one-cycle pulse on last cycle of each period.
REQ-016 busy  out  1  high while in RUN or BURST.
REQ-017 load_pending  out  1  shadow holds values not yet active.
REQ-018 burst_done  out  1  one-cycle pulse when a burst completes.

Function
REQ-019 States IDLE, RUN, BURST; one shared counter cnt, 0..P-1, P = active period.
REQ-020 IDLE: cnt = 0, pwm_out[k] = polarity_active[k] (inactive level).
REQ-021 IDLE -> RUN when en=1 and burst_mode=0; IDLE -> BURST when en=1, burst_mode=1, burst_start=1 and burst_len != 0.
REQ-022 burst_start with burst_len = 0 in IDLE: stay IDLE, burst_done pulses next cycle.
REQ-023 burst_mode sampled only in IDLE; changes during RUN/BURST ignored.
REQ-024 burst_start while in RUN or BURST ignored.
REQ-025 en=0 in RUN or BURST: IDLE next cycle, cnt cleared, no burst_done.
REQ-026 RUN/BURST: cnt increments each cycle, wraps to 0 after P-1; period_end = 1 exactly when cnt = P-1.
REQ-027 Active period value 0 or 1 treated as P = 1: cnt stays 0, period_end high every cycle.
REQ-028 pwm_out[k] active (1 ^ polarity_active[k]) when cnt < duty_active[k]; duty 0 = never active, duty >= P = always active.
REQ-029 pwm_out registered and aligned with cnt: first cycle in RUN/BURST shows cnt = 0 and its compare result.
REQ-030 BURST: burst counter loaded with burst_len on entry, decremented at each period_end; at period_end with count 1 -> IDLE and burst_done pulses same cycle as that period_end.
REQ-031 load: inputs written to shadow, load_pending set; repeated load overwrites shadow.
REQ-032 Shadow -> active transfer only at period_end cycle (new values govern cnt = 0 onward) or any cycle in IDLE; load_pending clears on transfer.
REQ-033 load coincident with period_end: the load inputs transfer directly to active at that boundary; load_pending stays 0.
REQ-034 Per-channel compare is unsigned, PERIOD_W bits; no arithmetic overflow possible.

Reset
REQ-035 rst low: state IDLE, cnt 0, shadow and active period/duty/polarity 0, burst counter 0, pwm_out 0, period_end 0, busy 0, load_pending 0, burst_done 0.
REQ-036 rst effect immediate (asynchronous), including mid-period and mid-burst; release synchronous to clk.

Verification
REQ-037 Continuous: load period=10, duty={0,3,10,12}, polarity=0, en=1 -> ch0 always 0, ch1 high cnt 0-2, ch2/ch3 always 1, period_end every 10 cycles.
REQ-038 Polarity: as REQ-037 with polarity=4'b0010 -> ch1 low 3 cycles, high 7; in IDLE ch1 = 1, others 0.
REQ-039 Shadow update: running period=8 duty=4, load period=16 duty=2 mid-period -> load_pending=1 until period_end; next period 16 cycles, 2 high.
REQ-040 Burst: burst_mode=1, period=5, burst_len=3, burst_start -> exactly 3 periods (15 cycles), burst_done with third period_end, busy falls next cycle; burst_len=0 -> only burst_done.
REQ-041 Abort: en=0 mid-burst -> IDLE next cycle, no burst_done; rst low mid-period -> all outputs 0 immediately.
REQ-042 Boundary: period=1 -> period_end constant 1; load coincident with period_end -> new values from next cnt = 0, load_pending never asserted.
